dds_multi_ch: RTL and testbench

Time-multiplexed, parametrised direct digital synthesiser. It generates N_CH independent sine channels from one shared sine LUT and one multiplier. Each channel has its own phase accumulator, frequency word, phase offset and amplitude, all loaded through a register-style config port. It is the next-generation DDS for the DSP AXI IP set: it feeds one interleaved sample stream, tagged with a channel index, to the downstream AXI-Stream packer.

---
 rtl/dds_multi_ch.sv | 229 ++++++++++++++++++++++
 tb/tb_dds_multi_ch.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multi_ch.sv
// Time-multiplexed multi-channel DDS.
// A single shared sine ROM and multiplier serve N_CH channels, one channel
// per clock. The result is one interleaved sample stream, and each sample
// carries its channel index.
// Pipeline: issue (phase) -> ROM read -> scale/round/saturate -> output.
`timescale 1ns/1ps
module dds_multi_ch #(
  parameter int N_CH        = 4,
  parameter int CH_W        = $clog2(N_CH),
  parameter int SIG_WIDTH   = 16,
  parameter int PHASE_WIDTH = 32,
  parameter int LUT_ADDR_W  = 8
) (
  input  logic                          clk,
  input  logic                          a_rst_n,
  input  logic                          i_soft_rst,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic                          i_cfg_we,
  input  logic [CH_W-1:0]               i_cfg_ch,
  input  logic [1:0]                    i_cfg_sel,
  input  logic [PHASE_WIDTH-1:0]        i_cfg_data,
  output logic                          o_busy,
  output logic                          o_valid,
  output logic [CH_W-1:0]               o_ch,
  output logic                          o_frame_start,
  output logic signed [SIG_WIDTH-1:0]   o_signal
);

  localparam int LUT_DEPTH = 1 << LUT_ADDR_W;
  localparam int SIN_PEAK  = (1 << (SIG_WIDTH - 1)) - 1;
  localparam logic signed [2*SIG_WIDTH-1:0] C_RND =
    {{(SIG_WIDTH + 1){1'b0}}, 1'b1, {(SIG_WIDTH - 2){1'b0}}};
  localparam logic signed [2*SIG_WIDTH-1:0] C_MAX =
    {{(SIG_WIDTH + 1){1'b0}}, {(SIG_WIDTH - 1){1'b1}}};
  localparam logic signed [2*SIG_WIDTH-1:0] C_MIN =
    {{(SIG_WIDTH + 1){1'b1}}, {(SIG_WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_t;
  typedef logic [LUT_DEPTH-1:0][SIG_WIDTH-1:0] lut_t;

  // The ROM contents are computed once, when the design is elaborated.
  function automatic lut_t gen_lut();
    lut_t t;
    real  a;
    int   v;
    for (int k = 0; k < LUT_DEPTH; k++) begin
      a = real'(SIN_PEAK) * $sin(2.0 * 3.14159265358979323846 * real'(k) / real'(LUT_DEPTH));
      v = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
      t[k] = v[SIG_WIDTH-1:0];
    end
    return t;
  endfunction

  localparam lut_t C_LUT = gen_lut();

  state_t                        r_state, w_state_nxt;
  logic [CH_W-1:0]               r_slot;
  logic                          r_stop_pend;
  logic [1:0]                    r_drain_cnt;
  logic                          w_issue;
  logic                          w_last_slot;

  logic [PHASE_WIDTH-1:0]        r_fcw [N_CH];
  logic [PHASE_WIDTH-1:0]        r_off [N_CH];
  logic signed [SIG_WIDTH-1:0]   r_amp [N_CH];
  logic [PHASE_WIDTH-1:0]        r_acc [N_CH];

  logic                          r_s0_valid, r_s1_valid;
  logic [LUT_ADDR_W-1:0]         r_s0_idx;
  logic signed [SIG_WIDTH-1:0]   r_s0_amp, r_s1_amp, r_s1_sine;
  logic [CH_W-1:0]               r_s0_ch, r_s1_ch;
  logic [LUT_ADDR_W-1:0]         w_lut_idx;
  logic signed [2*SIG_WIDTH-1:0] w_prod, w_scaled;
  logic signed [SIG_WIDTH-1:0]   w_sat;

  assign w_last_slot = (r_slot == CH_W'(N_CH - 1));
  // The ROM index is the top bits of (pre-increment accumulator + offset).
  assign w_lut_idx = LUT_ADDR_W'((r_acc[r_slot] + r_off[r_slot]) >> (PHASE_WIDTH - LUT_ADDR_W));

  // FSM state register
  // NOTE: sequential state always uses non-blocking (<=) so that every flop samples pre-edge values.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state: a stop only takes effect after the last slot of a frame
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (i_soft_rst) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (i_start && !i_stop)                  w_state_nxt = ST_RUN;
        ST_RUN:   if ((r_stop_pend || i_stop) && w_last_slot) w_state_nxt = ST_DRAIN;
        ST_DRAIN: if (r_drain_cnt == 2'd2)                 w_state_nxt = ST_IDLE;
        default:                                           w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: issue one slot per clock in RUN, busy whenever not idle
  always_comb begin
    w_issue = (r_state == ST_RUN);
    o_busy  = (r_state != ST_IDLE);
  end

  // Slot counter, pending-stop flag and drain timer
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_slot      <= '0;
      r_stop_pend <= 1'b0;
      r_drain_cnt <= '0;
    end else if (i_soft_rst) begin
      r_slot      <= '0;
      r_stop_pend <= 1'b0;
      r_drain_cnt <= '0;
    end else begin
      r_slot      <= (w_issue && !w_last_slot) ? r_slot + 1'b1 : '0;
      r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
      if (r_state == ST_RUN && i_stop)
        r_stop_pend <= 1'b1;
      else if (r_state == ST_DRAIN && w_state_nxt == ST_IDLE)
        r_stop_pend <= 1'b0;
    end
  end

  // Per-channel config registers; only the async reset clears them
  // NOTE: these arrays are a few flops per channel, so they take a reset; a true RAM would not.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_fcw[c] <= '0;
        r_off[c] <= '0;
        r_amp[c] <= '0;
      end
    end else if (i_cfg_we) begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_cfg_ch == CH_W'(c)) begin
          case (i_cfg_sel)
            2'd0:    r_fcw[c] <= i_cfg_data;
            2'd1:    r_off[c] <= i_cfg_data;
            2'd2:    r_amp[c] <= i_cfg_data[SIG_WIDTH-1:0];
            default: ;
          endcase
        end
      end
    end
  end

  // Phase accumulators: a clear write wins over a same-cycle advance
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      for (int c = 0; c < N_CH; c++) r_acc[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (i_soft_rst)
          r_acc[c] <= '0;
        else if (i_cfg_we && i_cfg_sel == 2'd3 && i_cfg_ch == CH_W'(c))
          r_acc[c] <= '0;
        else if (w_issue && r_slot == CH_W'(c))
          r_acc[c] <= r_acc[c] + r_fcw[c];
      end
    end
  end

  assign w_prod   = r_s1_amp * r_s1_sine;
  assign w_scaled = (w_prod + C_RND) >>> (SIG_WIDTH - 1);

  // Clamp the rounded product into the signed output range
  always_comb begin
    w_sat = SIG_WIDTH'(w_scaled);
    if (w_scaled > C_MAX)      w_sat = SIG_WIDTH'(C_MAX);
    else if (w_scaled < C_MIN) w_sat = SIG_WIDTH'(C_MIN);
  end

  // Three-stage sample pipeline: issue, ROM read, scale to output
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      r_s0_valid    <= 1'b0;
      r_s0_idx      <= '0;
      r_s0_amp      <= '0;
      r_s0_ch       <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_amp      <= '0;
      r_s1_sine     <= '0;
      r_s1_ch       <= '0;
      o_valid       <= 1'b0;
      o_ch          <= '0;
      o_frame_start <= 1'b0;
      o_signal      <= '0;
    end else if (i_soft_rst) begin
      r_s0_valid    <= 1'b0;
      r_s0_idx      <= '0;
      r_s0_amp      <= '0;
      r_s0_ch       <= '0;
      r_s1_valid    <= 1'b0;
      r_s1_amp      <= '0;
      r_s1_sine     <= '0;
      r_s1_ch       <= '0;
      o_valid       <= 1'b0;
      o_ch          <= '0;
      o_frame_start <= 1'b0;
      o_signal      <= '0;
    end else begin
      r_s0_valid <= w_issue;
      if (w_issue) begin
        r_s0_idx <= w_lut_idx;
        r_s0_amp <= r_amp[r_slot];
        r_s0_ch  <= r_slot;
      end
      r_s1_valid <= r_s0_valid;
      if (r_s0_valid) begin
        r_s1_sine <= C_LUT[r_s0_idx];
        r_s1_amp  <= r_s0_amp;
        r_s1_ch   <= r_s0_ch;
      end
      o_valid       <= r_s1_valid;
      o_frame_start <= r_s1_valid && (r_s1_ch == '0);
      if (r_s1_valid) begin
        o_ch     <= r_s1_ch;
        o_signal <= w_sat;
      end
    end
  end

endmodule

// File: tb/tb_dds_multi_ch.sv
// Directed bench for dds_multi_ch.
// Expected samples are hand-computed from round(32767*sin(2*pi*k/256)) and
// the round-half-up / arithmetic-shift scaling.
`timescale 1ns/1ps
module tb_dds_multi_ch;

  localparam int N_CH = 4;
  localparam int CH_W = 2;
  localparam int SW   = 16;
  localparam int PW   = 32;

  logic                 clk;
  logic                 a_rst_n;
  logic                 i_soft_rst;
  logic                 i_start;
  logic                 i_stop;
  logic                 i_cfg_we;
  logic [CH_W-1:0]      i_cfg_ch;
  logic [1:0]           i_cfg_sel;
  logic [PW-1:0]        i_cfg_data;
  logic                 o_busy;
  logic                 o_valid;
  logic [CH_W-1:0]      o_ch;
  logic                 o_frame_start;
  logic signed [SW-1:0] o_signal;

  int vectors     = 0;
  int miscompares = 0;
  int exp_tab[24];

  dds_multi_ch #(
    .N_CH(N_CH), .SIG_WIDTH(SW), .PHASE_WIDTH(PW), .LUT_ADDR_W(8)
  ) dut (
    .clk(clk), .a_rst_n(a_rst_n), .i_soft_rst(i_soft_rst),
    .i_start(i_start), .i_stop(i_stop),
    .i_cfg_we(i_cfg_we), .i_cfg_ch(i_cfg_ch), .i_cfg_sel(i_cfg_sel),
    .i_cfg_data(i_cfg_data),
    .o_busy(o_busy), .o_valid(o_valid), .o_ch(o_ch),
    .o_frame_start(o_frame_start), .o_signal(o_signal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are read 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic [1:0] sel,
                           input logic [31:0] d);
    i_cfg_we   = 1'b1;
    i_cfg_ch   = ch;
    i_cfg_sel  = sel;
    i_cfg_data = d;
    step();
    i_cfg_we   = 1'b0;
  endtask

  // Start, check n consecutive samples against exp_tab, with optional
  // stop / amplitude-write / accumulator-clear events at output index k.
  task automatic run_seq(input string name, input int n, input int stop_at,
                         input int amp_at, input int clr_at);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    step();
    check($sformatf("%s_latency", name), o_valid, 0);
    step();
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_valid[%0d]", name, k), o_valid, 1);
      check($sformatf("%s_ch[%0d]", name, k), o_ch, k % N_CH);
      check($sformatf("%s_fs[%0d]", name, k), o_frame_start, (k % N_CH) == 0);
      check($sformatf("%s_sig[%0d]", name, k), $signed(o_signal), exp_tab[k]);
      check($sformatf("%s_busy[%0d]", name, k), o_busy, 1);
      if (k == stop_at) i_stop = 1'b1;
      if (k == amp_at) begin
        i_cfg_we = 1'b1; i_cfg_ch = 2'd2; i_cfg_sel = 2'd2; i_cfg_data = 32'h0000_4000;
      end
      if (k == clr_at) begin
        i_cfg_we = 1'b1; i_cfg_ch = 2'd0; i_cfg_sel = 2'd3; i_cfg_data = 32'h0;
      end
      step();
      i_stop   = 1'b0;
      i_cfg_we = 1'b0;
    end
    check($sformatf("%s_end_valid", name), o_valid, 0);
    check($sformatf("%s_end_busy", name), o_busy, 0);
  endtask

  initial begin
    int c0_tone[4];
    int c3_tone[4];
    int c0_live[5];
    int c2_live[5];
    int c3_live[5];
    c0_tone = '{0, 804, 1608, 2410};
    c3_tone = '{0, -32766, 0, 32766};
    c0_live = '{0, 804, 1608, 0, 804};
    c2_live = '{32766, 32766, 16384, 16384, 16384};
    c3_live = '{0, 32767, 0, -32767, 0};

    a_rst_n = 1'b0; i_soft_rst = 1'b0; i_start = 1'b0; i_stop = 1'b0;
    i_cfg_we = 1'b0; i_cfg_ch = '0; i_cfg_sel = '0; i_cfg_data = '0;
    step(); step();
    check("rst_valid", o_valid, 0);
    check("rst_ch", o_ch, 0);
    check("rst_fs", o_frame_start, 0);
    check("rst_sig", $signed(o_signal), 0);
    check("rst_busy", o_busy, 0);
    a_rst_n = 1'b1;
    step();

    // ch0 ramp, ch1 cosine peak via offset, ch2 half-turn, ch3 quarter-turn steps
    cfg_write(2'd0, 2'd0, 32'h0100_0000);
    cfg_write(2'd0, 2'd2, 32'h0000_7FFF);
    cfg_write(2'd1, 2'd1, 32'h4000_0000);
    cfg_write(2'd1, 2'd2, 32'h0000_7FFF);
    cfg_write(2'd2, 2'd0, 32'h8000_0000);
    cfg_write(2'd2, 2'd2, 32'h0000_7FFF);
    cfg_write(2'd3, 2'd0, 32'hC000_0000);
    cfg_write(2'd3, 2'd2, 32'h0000_7FFF);
    for (int f = 0; f < 4; f++) begin
      exp_tab[4*f+0] = c0_tone[f];
      exp_tab[4*f+1] = 32766;
      exp_tab[4*f+2] = 0;
      exp_tab[4*f+3] = c3_tone[f];
    end
    run_seq("tone", 16, 10, -1, -1);

    // start and stop together in IDLE: nothing happens
    i_start = 1'b1; i_stop = 1'b1;
    step();
    i_start = 1'b0; i_stop = 1'b0;
    check("startstop_busy", o_busy, 0);
    repeat (5) step();
    check("startstop_valid", o_valid, 0);
    check("startstop_busy_late", o_busy, 0);

    // soft reset mid-RUN, then a restart must repeat the first run
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (6) step();
    check("sr_pre_valid", o_valid, 1);
    i_soft_rst = 1'b1;
    step();
    i_soft_rst = 1'b0;
    check("sr_valid", o_valid, 0);
    check("sr_busy", o_busy, 0);
    check("sr_sig", $signed(o_signal), 0);
    check("sr_fs", o_frame_start, 0);
    step();
    check("sr_valid_next", o_valid, 0);
    run_seq("restart", 8, 2, -1, -1);

    // live config: ch2 amp change and ch0 accumulator clear during their issue slots
    i_soft_rst = 1'b1;
    step();
    i_soft_rst = 1'b0;
    cfg_write(2'd2, 2'd0, 32'h0000_0000);
    cfg_write(2'd2, 2'd1, 32'h4000_0000);
    cfg_write(2'd3, 2'd2, 32'h0000_8000);
    for (int f = 0; f < 5; f++) begin
      exp_tab[4*f+0] = c0_live[f];
      exp_tab[4*f+1] = 32766;
      exp_tab[4*f+2] = c2_live[f];
      exp_tab[4*f+3] = c3_live[f];
    end
    run_seq("live", 20, 14, 3, 5);

    // async reset mid-RUN clears outputs at once and wipes the config
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (5) step();
    check("ar_pre_valid", o_valid, 1);
    #2 a_rst_n = 1'b0;
    #1;
    check("ar_valid", o_valid, 0);
    check("ar_ch", o_ch, 0);
    check("ar_fs", o_frame_start, 0);
    check("ar_sig", $signed(o_signal), 0);
    check("ar_busy", o_busy, 0);
    step();
    a_rst_n = 1'b1;
    step();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    repeat (3) step();
    check("ar_run_valid", o_valid, 1);
    check("ar_run_sig", $signed(o_signal), 0);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    repeat (8) step();
    check("ar_run_busy", o_busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
